// File: rtl/ccg_lut_pipe_if.sv
// Bundle of config, input, output and signature signals for ccg_lut_pipe.
// The master modport drives stimulus; the slave modport is the LUT pipe itself.
interface ccg_lut_pipe_if #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 16
);
  localparam int unsigned T = 1 << N_IN;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [T-1:0]     cfg_data;
  logic             cfg_last;
  logic             cfg_err;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_x;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_f;
  logic             sig_clr;
  logic [N_OUT-1:0] sig;
  logic [1:0]       state;

  modport master (
    output cfg_valid, cfg_data, cfg_last, in_valid, in_x, out_ready, sig_clr,
    input  cfg_ready, cfg_err, in_ready, out_valid, out_f, sig, state
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_last, in_valid, in_x, out_ready, sig_clr,
    output cfg_ready, cfg_err, in_ready, out_valid, out_f, sig, state
  );
endinterface

// File: rtl/ccg_lut_pipe.sv
// Programmable N_IN-input / N_OUT-output truth-table evaluator with a
// stallable PIPE-stage valid/ready pipeline and a MISR over every result.
module ccg_lut_pipe #(
  parameter int unsigned N_IN      = 3,
  parameter int unsigned N_OUT     = 16,
  parameter int unsigned PIPE      = 2,
  parameter logic [31:0] MISR_POLY = 32'h0000_B400
) (
  input logic           clk,
  input logic           rst,
  ccg_lut_pipe_if.slave bus_io
);
  localparam int unsigned T    = 1 << N_IN;
  localparam int unsigned IdxW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(N_OUT - 1);
  localparam logic [N_OUT-1:0] Poly    = MISR_POLY[N_OUT-1:0];

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             err_q, err_d;
  logic [T-1:0]     tbl_q [N_OUT];
  logic [PIPE-1:0]  vld_q;
  logic [N_OUT-1:0] dat_q [PIPE];
  logic [N_OUT-1:0] sig_q, sig_d;
  logic [N_OUT-1:0] lookup;
  logic             adv, pipe_busy, cfg_ready, in_ready;
  logic             cfg_hs, in_hs, out_hs;

  assign adv       = !vld_q[PIPE-1] || bus_io.out_ready;
  assign pipe_busy = |vld_q;
  assign cfg_hs    = bus_io.cfg_valid && cfg_ready;
  assign in_hs     = bus_io.in_valid && in_ready;
  assign out_hs    = vld_q[PIPE-1] && bus_io.out_ready;

  // Handshake readiness: config is only taken in RUN once nothing is in flight.
  always_comb begin
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    unique case (state_q)
      StIdle, StLoad: cfg_ready = 1'b1;
      StRun: begin
        cfg_ready = !pipe_busy && !bus_io.in_valid;
        in_ready  = adv;
      end
      default: ;
    endcase
  end

  // Config framing: index is 0 in IDLE and RUN, so one rule covers every state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    if (cfg_hs) begin
      if (idx_q == LastIdx) begin
        idx_d = '0;
        if (bus_io.cfg_last) begin
          state_d = StRun;
        end else begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end else if (bus_io.cfg_last) begin
        idx_d   = '0;
        state_d = StIdle;
        err_d   = 1'b1;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = StLoad;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Truth-table storage, written by every accepted config beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(N_OUT); k++) tbl_q[k] <= '0;
    end else if (cfg_hs) begin
      tbl_q[idx_q] <= bus_io.cfg_data;
    end
  end

  // Table lookup at stage 0: bit k is table k indexed by the input vector.
  always_comb begin
    lookup = '0;
    for (int k = 0; k < int'(N_OUT); k++) lookup[k] = tbl_q[k][bus_io.in_x];
  end

  // Pipeline: everything shifts on adv; data only moves behind a valid so
  // out_f keeps its last value across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(PIPE); i++) dat_q[i] <= '0;
    end else if (adv) begin
      vld_q[0] <= in_hs;
      if (in_hs) dat_q[0] <= lookup;
      for (int i = 1; i < int'(PIPE); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  // MISR next state; clear wins over a same-cycle output handshake.
  always_comb begin
    sig_d = sig_q;
    if (bus_io.sig_clr) begin
      sig_d = '0;
    end else if (out_hs) begin
      sig_d = {sig_q[N_OUT-2:0], 1'b0} ^ (sig_q[N_OUT-1] ? Poly : '0) ^ dat_q[PIPE-1];
    end
  end

  // Signature register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign bus_io.cfg_ready = cfg_ready;
  assign bus_io.in_ready  = in_ready;
  assign bus_io.cfg_err   = err_q;
  assign bus_io.out_valid = vld_q[PIPE-1];
  assign bus_io.out_f     = dat_q[PIPE-1];
  assign bus_io.sig       = sig_q;
  assign bus_io.state     = state_q;
endmodule

// File: tb/tb_ccg_lut_pipe.sv
// Scoreboard bench for ccg_lut_pipe: stimulus pushes expected results computed
// from a truth-table model; a negedge monitor pops, compares and tracks the MISR.
module tb_ccg_lut_pipe;
  localparam int unsigned N_IN  = 3;
  localparam int unsigned N_OUT = 16;
  localparam int unsigned PIPE  = 2;
  localparam int unsigned T     = 1 << N_IN;
  localparam logic [31:0] POLY  = 32'h0000_B400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [T-1:0]     m_tbl   [N_OUT];
  logic [T-1:0]     new_tbl [N_OUT];
  logic [N_OUT-1:0] m_sig = '0;
  logic [N_OUT-1:0] exp_q [$];
  int               in_cycles  [$];
  int               out_cycles [$];
  logic [N_OUT-1:0] f_hold;
  logic             done;

  ccg_lut_pipe_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  ccg_lut_pipe #(
    .N_IN(N_IN), .N_OUT(N_OUT), .PIPE(PIPE), .MISR_POLY(POLY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected result: bit k is entry x of table k.
  function automatic logic [N_OUT-1:0] model_f(input logic [N_IN-1:0] x);
    logic [N_OUT-1:0] r = '0;
    for (int k = 0; k < int'(N_OUT); k++) r[k] = m_tbl[k][int'(x)];
    return r;
  endfunction

  // Signature step: double modulo 2^N_OUT, fold in taps on overflow, add data.
  function automatic logic [N_OUT-1:0] misr(input logic [N_OUT-1:0] s,
                                            input logic [N_OUT-1:0] f);
    longint unsigned m = (64'd1 << N_OUT);
    longint unsigned v = (longint'(s) * 2) % m;
    if (longint'(s) >= m / 2) v = v ^ (longint'(POLY) % m);
    v = v ^ longint'(f);
    return v[N_OUT-1:0];
  endfunction

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_sig = '0;
        exp_q.delete();
      end else begin
        check("sig", 32'(bus.sig), 32'(m_sig));
        if (bus.out_valid && bus.out_ready) begin
          logic [N_OUT-1:0] e;
          e = bus.out_f;
          check("exp_avail", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_f", 32'(bus.out_f), 32'(e));
          end
          out_cycles.push_back(cyc);
          m_sig = bus.sig_clr ? '0 : misr(m_sig, e);
        end else if (bus.sig_clr) begin
          m_sig = '0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [N_IN-1:0] x);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("in_accept", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready) begin
      exp_q.push_back(model_f(x));
      in_cycles.push_back(cyc);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic cfg_beat(input logic [T-1:0] d, input logic last);
    int n = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = d;
    bus.cfg_last  = last;
    @(negedge clk);
    while (!bus.cfg_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("cfg_accept", 32'(bus.cfg_ready), 32'd1);
    tick();
    bus.cfg_valid = 1'b0;
    bus.cfg_last  = 1'b0;
  endtask

  task automatic load_tables();
    for (int k = 0; k < int'(N_OUT); k++) cfg_beat(new_tbl[k], k == int'(N_OUT) - 1);
    for (int k = 0; k < int'(N_OUT); k++) m_tbl[k] = new_tbl[k];
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  task automatic wait_out_valid();
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("out_valid_seen", 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.cfg_last  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.out_ready = 1'b0;
    bus.sig_clr   = 1'b0;
    for (int k = 0; k < int'(N_OUT); k++) m_tbl[k] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset / idle: inputs are ignored outside RUN.
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    check("rst_out_f", 32'(bus.out_f), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      check("idle_in_ready", 32'(bus.in_ready), 32'd0);
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      check("idle_sig", 32'(bus.sig), 32'd0);
      check("idle_state", 32'(bus.state), 32'd0);
    end
    tick();
    bus.in_valid = 1'b0;

    // XOR(x0,x1) in every output, streamed back to back.
    for (int k = 0; k < int'(N_OUT); k++) new_tbl[k] = 8'h66;
    load_tables();
    @(negedge clk);
    check("load_state", 32'(bus.state), 32'd2);
    tick();
    bus.out_ready = 1'b1;
    in_cycles.delete();
    out_cycles.delete();
    for (int x = 0; x < 8; x++) send_vec(N_IN'(x));
    drain();
    check("out_count", 32'(out_cycles.size()), 32'd8);
    for (int i = 0; i < 8 && i < out_cycles.size(); i++)
      check("latency", 32'(out_cycles[i] - in_cycles[i]), 32'(PIPE));

    // Backpressure: hold out_ready low once the pipe fills.
    for (int k = 0; k < int'(N_OUT); k++) new_tbl[k] = T'($urandom);
    load_tables();
    fork
      for (int i = 0; i < 8; i++) send_vec(N_IN'($urandom));
      begin
        bus.out_ready = 1'b0;
        wait_out_valid();
        f_hold = bus.out_f;
        repeat (3) begin
          @(negedge clk);
          check("stall_out_f", 32'(bus.out_f), 32'(f_hold));
          check("stall_out_valid", 32'(bus.out_valid), 32'd1);
          check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        tick();
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random gaps and random backpressure.
    for (int k = 0; k < int'(N_OUT); k++) new_tbl[k] = T'($urandom);
    load_tables();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send_vec(N_IN'($urandom));
          repeat ($urandom_range(0, 2)) tick();
        end
        done = 1'b1;
      end
      while (!done) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Framing error: cfg_last on the fifth beat.
    for (int i = 0; i < 5; i++) cfg_beat(T'($urandom), i == 4);
    @(negedge clk);
    check("frame_err", 32'(bus.cfg_err), 32'd1);
    check("frame_state", 32'(bus.state), 32'd0);
    tick();
    for (int k = 0; k < int'(N_OUT); k++) new_tbl[k] = 8'h01;
    load_tables();
    @(negedge clk);
    check("reload_state", 32'(bus.state), 32'd2);
    check("err_sticky", 32'(bus.cfg_err), 32'd1);
    tick();

    // MISR from a cleared signature.
    bus.sig_clr = 1'b1;
    tick();
    bus.sig_clr = 1'b0;
    send_vec(3'd0);
    drain();
    check("misr_first", 32'(bus.sig), 32'h0000_FFFF);
    send_vec(3'd1);
    drain();
    check("misr_second", 32'(bus.sig), 32'h0000_4BFE);
    bus.out_ready = 1'b0;
    send_vec(3'd5);
    wait_out_valid();
    tick();
    bus.sig_clr   = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.sig_clr = 1'b0;
    @(negedge clk);
    check("sig_clr_hs", 32'(bus.sig), 32'd0);
    check("sig_clr_drained", 32'(exp_q.size()), 32'd0);
    tick();

    // Reconfig request while a vector is stuck in the pipe.
    bus.out_ready = 1'b0;
    send_vec(3'd2);
    for (int k = 0; k < int'(N_OUT); k++) new_tbl[k] = 8'h66;
    fork
      load_tables();
      begin
        repeat (3) begin
          @(negedge clk);
          check("busy_cfg_ready", 32'(bus.cfg_ready), 32'd0);
          check("busy_state", 32'(bus.state), 32'd2);
        end
        tick();
        bus.out_ready = 1'b1;
      end
    join
    @(negedge clk);
    check("reconfig_state", 32'(bus.state), 32'd2);
    check("reconfig_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // Async reset mid-LOAD with a nonzero signature and sticky error.
    send_vec(3'd1);
    drain();
    for (int i = 0; i < 3; i++) cfg_beat(T'($urandom), 1'b0);
    @(negedge clk);
    check("mid_load_state", 32'(bus.state), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("arst_in_ready", 32'(bus.in_ready), 32'd0);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_f", 32'(bus.out_f), 32'd0);
    check("arst_sig", 32'(bus.sig), 32'd0);
    check("arst_cfg_err", 32'(bus.cfg_err), 32'd0);
    check("arst_state", 32'(bus.state), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < int'(N_OUT); k++) m_tbl[k] = '0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
